// File: rtl/mux_4x1_rr_arbiter_if.sv
// Bundles the requester-side signals of the 4:1 mux round-robin arbiter.
// The master side drives requests, data and lock. The slave side (the arbiter) returns grant and mux output.
interface mux_4x1_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] d;
  logic       lock;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       y_vld;

  modport master (
    output req, d, lock,
    input  gnt, sel, y, y_vld
  );

  modport slave (
    input  req, d, lock,
    output gnt, sel, y, y_vld
  );
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter that owns a shared 4:1 1-bit mux, with bounded grant tenure.
// Optional macro MUX_ARB_LOCK_EN: while lock=1, the current owner cannot be preempted.
module mux_4x1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mux_4x1_rr_arbiter_if.slave  bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : gen_bad_max_hold
    $error("MAX_HOLD must be in 1..15");
  end

  localparam logic [3:0] MaxHoldCnt = 4'(MAX_HOLD);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       y_q, y_vld_q;

  logic [3:0] others;
  logic [1:0] win;
  logic       hold_lock;

`ifdef MUX_ARB_LOCK_EN
  assign hold_lock = bus.lock;
`else
  logic unused_lock;
  assign unused_lock = bus.lock;
  assign hold_lock   = 1'b0;
`endif

  // Search order is ptr+1, ptr+2, ptr+3, then ptr. Smaller offsets overwrite later.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] mask);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  // gnt_q is zero in idle, so the same masked pick serves both states.
  assign others = bus.req & ~gnt_q;
  assign win    = rr_pick(ptr_q, others);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          ptr_d   = win;
          hold_d  = 4'd1;
        end
      end
      StGrant: begin
        if (!bus.req[sel_q]) begin
          if (|others) begin
            gnt_d  = 4'b0001 << win;
            sel_d  = win;
            ptr_d  = win;
            hold_d = 4'd1;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
          end
        end else if (hold_q == MaxHoldCnt && |others && !hold_lock) begin
          gnt_d  = 4'b0001 << win;
          sel_d  = win;
          ptr_d  = win;
          hold_d = 4'd1;
        end else if (hold_q != MaxHoldCnt) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd3;
      hold_q  <= 4'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      y_q     <= 1'b0;
      y_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      if (|gnt_q) y_q <= bus.d[sel_q];
      y_vld_q <= |gnt_q;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.y     = y_q;
  assign bus.y_vld = y_vld_q;

endmodule
